// File: rtl/kzr_sample_fifo.sv
// kzr_sample_fifo
// Small synchronous FIFO sitting behind the XOR-gate stage. It captures
// 3-bit samples ([0:2], bit 0 is the MSB) on a valid/ready handshake and
// presents the head word with its parity. Alongside the data path it keeps
// a saturating count of the ones seen in accepted samples, plus a sticky
// flag recording that upstream ever offered a word while the FIFO was full.
// Every handshake output is a function of registered state only, so the
// FIFO breaks the timing path between source and sink.

module kzr_sample_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic [0:2]               in_vec,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [0:2]               out_word,
   output logic                     out_parity,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         ones_cnt,
   output logic                     stall_seen
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

   logic [0:2]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   logic [1:0]       in_ones;
   logic [CNT_W:0]   cnt_sum;
   logic [CNT_W-1:0] cnt_next;

   // Status flags come straight from the occupancy register, so in_ready
   // and out_valid never depend on the current cycle's handshake inputs.
   assign full      = (level == FULL_LEVEL);
   assign empty     = (level == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // The head word is forced to zero when nothing is stored, so a stale
   // array entry is never visible on the output.
   assign out_word   = empty ? 3'b000 : mem[rd_ptr];
   assign out_parity = ^out_word;

   // Popcount of the incoming sample and the widened sum used for
   // saturation detection; the extra top bit flags overflow.
   assign in_ones  = {1'b0, in_vec[0]} + {1'b0, in_vec[1]} + {1'b0, in_vec[2]};
   assign cnt_sum  = {1'b0, ones_cnt} + {{(CNT_W-1){1'b0}}, in_ones};
   assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

   // Storage array: written on an accepted push, deliberately not reset.
   always_ff @(posedge clk) begin
      if (push && !clr) begin
         mem[wr_ptr] <= in_vec;
      end
   end

   // Write and read pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Occupancy: up on push alone, down on pop alone, held when both or neither.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= '0;
      end else if (clr) begin
         level <= '0;
      end else begin
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Saturating count of ones over accepted samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_cnt <= '0;
      end else if (clr) begin
         ones_cnt <= '0;
      end else if (push) begin
         ones_cnt <= cnt_next;
      end
   end

   // Sticky record of upstream offering a word while the FIFO was full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_seen <= 1'b0;
      end else if (clr) begin
         stall_seen <= 1'b0;
      end else if (in_valid && full) begin
         stall_seen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_kzr_sample_fifo.sv
// tb_kzr_sample_fifo
// Drives kzr_sample_fifo with a directed vector table, hand-written
// streaming and saturation sequences, and a randomized run that includes
// clr pulses and an asynchronous reset. A queue-based model tracks the
// expected contents, ones count and stall flag. A second instance with a
// 4-bit accumulator shares the stimulus and is used to observe saturation.

module tb_kzr_sample_fifo;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic [0:2] in_vec = 3'b000;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;

   logic       in_ready;
   logic [0:2] out_word;
   logic       out_parity;
   logic       out_valid;
   logic [2:0] level;
   logic [7:0] ones_cnt;
   logic       stall_seen;

   logic       s_in_ready;
   logic [0:2] s_out_word;
   logic       s_out_parity;
   logic       s_out_valid;
   logic [2:0] s_level;
   logic [3:0] s_ones_cnt;
   logic       s_stall_seen;

   int checks = 0;
   int failures = 0;

   // Behavioural model state
   logic [2:0] mq[$];
   int         m_cnt;
   int         m_cnt4;
   bit         m_stall;

   typedef struct {
      bit         c;
      bit         v;
      logic [2:0] vec;
      bit         r;
      int         ir;
      int         ov;
      int         word;
      int         par;
      int         lvl;
      int         cnt;
      int         stall;
   } vec_t;

   vec_t tv[$];

   kzr_sample_fifo #(.DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .in_vec     (in_vec),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_word   (out_word),
      .out_parity (out_parity),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .level      (level),
      .ones_cnt   (ones_cnt),
      .stall_seen (stall_seen)
   );

   kzr_sample_fifo #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .in_vec     (in_vec),
      .in_valid   (in_valid),
      .in_ready   (s_in_ready),
      .out_word   (s_out_word),
      .out_parity (s_out_parity),
      .out_valid  (s_out_valid),
      .out_ready  (out_ready),
      .level      (s_level),
      .ones_cnt   (s_ones_cnt),
      .stall_seen (s_stall_seen)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   function automatic int popc(input logic [2:0] v);
      return int'(v[0]) + int'(v[1]) + int'(v[2]);
   endfunction

   function automatic int minInt(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      m_cnt   = 0;
      m_cnt4  = 0;
      m_stall = 0;
   endtask

   // Drive one cycle of inputs, advance the model by the same rules, then
   // step past the rising edge so outputs can be sampled.
   task automatic applyStimulus(input bit c, input bit v, input logic [2:0] vec, input bit r);
      bit model_full;
      bit do_push;
      bit do_pop;
      clr       = c;
      in_valid  = v;
      in_vec    = vec;
      out_ready = r;
      if (c) begin
         modelReset();
      end else begin
         model_full = (mq.size() == DEPTH);
         do_push    = v && !model_full;
         do_pop     = r && (mq.size() > 0);
         if (v && model_full) m_stall = 1;
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back(vec);
            m_cnt  = minInt(m_cnt + popc(vec), 255);
            m_cnt4 = minInt(m_cnt4 + popc(vec), 15);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkState(input string tag, input int e_ir, input int e_ov, input int e_word,
                             input int e_par, input int e_lvl, input int e_cnt, input int e_stall);
      checkOutput({tag, ".in_ready"},   int'(in_ready),   e_ir);
      checkOutput({tag, ".out_valid"},  int'(out_valid),  e_ov);
      checkOutput({tag, ".out_word"},   int'(out_word),   e_word);
      checkOutput({tag, ".out_parity"}, int'(out_parity), e_par);
      checkOutput({tag, ".level"},      int'(level),      e_lvl);
      checkOutput({tag, ".ones_cnt"},   int'(ones_cnt),   e_cnt);
      checkOutput({tag, ".stall_seen"}, int'(stall_seen), e_stall);
   endtask

   task automatic checkModel(input string tag);
      int w;
      w = (mq.size() > 0) ? int'(mq[0]) : 0;
      checkState(tag, (mq.size() != DEPTH) ? 1 : 0, (mq.size() > 0) ? 1 : 0, w,
                 popc(3'(w)) % 2, mq.size(), m_cnt, int'(m_stall));
      checkOutput({tag, ".cnt4"}, int'(s_ones_cnt), m_cnt4);
   endtask

   initial begin
      int exp_sum;
      int exp4;
      string tag;

      // Directed vectors: {clr, valid, vec, ready, in_ready, out_valid, word, parity, level, cnt, stall}
      tv.push_back(vec_t'{0, 1, 3'b101, 0, 1, 1, 5, 0, 1,  2, 0});
      tv.push_back(vec_t'{0, 1, 3'b111, 0, 1, 1, 5, 0, 2,  5, 0});
      tv.push_back(vec_t'{0, 1, 3'b000, 0, 1, 1, 5, 0, 3,  5, 0});
      tv.push_back(vec_t'{0, 1, 3'b011, 0, 0, 1, 5, 0, 4,  7, 0});
      tv.push_back(vec_t'{0, 0, 3'b000, 1, 1, 1, 7, 1, 3,  7, 0});
      tv.push_back(vec_t'{0, 0, 3'b000, 1, 1, 1, 0, 0, 2,  7, 0});
      tv.push_back(vec_t'{0, 0, 3'b000, 1, 1, 1, 3, 0, 1,  7, 0});
      tv.push_back(vec_t'{0, 0, 3'b000, 1, 1, 0, 0, 0, 0,  7, 0});
      tv.push_back(vec_t'{0, 1, 3'b001, 0, 1, 1, 1, 1, 1,  8, 0});
      tv.push_back(vec_t'{0, 1, 3'b010, 0, 1, 1, 1, 1, 2,  9, 0});
      tv.push_back(vec_t'{0, 1, 3'b100, 0, 1, 1, 1, 1, 3, 10, 0});
      tv.push_back(vec_t'{0, 1, 3'b111, 0, 0, 1, 1, 1, 4, 13, 0});
      tv.push_back(vec_t'{0, 1, 3'b110, 0, 0, 1, 1, 1, 4, 13, 1});
      tv.push_back(vec_t'{0, 1, 3'b110, 0, 0, 1, 1, 1, 4, 13, 1});
      tv.push_back(vec_t'{0, 1, 3'b110, 1, 1, 1, 2, 1, 3, 13, 1});
      tv.push_back(vec_t'{0, 1, 3'b110, 0, 0, 1, 2, 1, 4, 15, 1});
      tv.push_back(vec_t'{0, 0, 3'b000, 1, 1, 1, 4, 1, 3, 15, 1});
      tv.push_back(vec_t'{0, 0, 3'b000, 1, 1, 1, 7, 1, 2, 15, 1});
      tv.push_back(vec_t'{0, 0, 3'b000, 1, 1, 1, 6, 0, 1, 15, 1});
      tv.push_back(vec_t'{0, 0, 3'b000, 1, 1, 0, 0, 0, 0, 15, 1});
      tv.push_back(vec_t'{0, 1, 3'b001, 0, 1, 1, 1, 1, 1, 16, 1});
      tv.push_back(vec_t'{0, 1, 3'b010, 0, 1, 1, 1, 1, 2, 17, 1});
      tv.push_back(vec_t'{1, 1, 3'b111, 1, 1, 0, 0, 0, 0,  0, 0});

      // Reset held for three cycles, then released
      modelReset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkState("reset_low", 1, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkState("reset_idle", 1, 0, 0, 0, 0, 0, 0);

      // Directed table: fill/drain, full stall, clr priority
      foreach (tv[i]) begin
         applyStimulus(tv[i].c, tv[i].v, tv[i].vec, tv[i].r);
         tag = $sformatf("vec%0d", i);
         checkState(tag, tv[i].ir, tv[i].ov, tv[i].word, tv[i].par, tv[i].lvl, tv[i].cnt, tv[i].stall);
      end

      // Streaming at one word per cycle
      exp_sum = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 1, 3'(i % 8), 1);
         exp_sum += popc(3'(i % 8));
         checkOutput($sformatf("stream%0d.level", i), int'(level), 1);
         checkOutput($sformatf("stream%0d.word", i), int'(out_word), i % 8);
      end
      checkOutput("stream.ones_cnt", int'(ones_cnt), exp_sum);
      applyStimulus(0, 0, 3'b000, 1);
      checkOutput("stream.drained", int'(out_valid), 0);

      // Saturation on the 4-bit accumulator instance
      applyStimulus(1, 0, 3'b000, 0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 1, 3'b111, 1);
         exp4 = minInt(3 * (k + 1), 15);
         checkOutput($sformatf("sat%0d.cnt4", k), int'(s_ones_cnt), exp4);
      end
      checkOutput("sat.cnt8", int'(ones_cnt), 18);

      // Randomized traffic against the model, with a mid-run async reset
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            in_valid = 1'b1;
            rst_n = 1'b0;
            #1;
            modelReset();
            checkModel("rand_async_reset");
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
         applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                       3'($urandom_range(0, 7)), ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 4 : 8)));
         checkModel($sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
